// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the burst dispatcher
package demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/demux_dispatch_if.sv
// rtl/demux_dispatch_if.sv - producer, consumer and control signals of the dispatcher
interface demux_dispatch_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ready;
    ch_t              sel;
    logic             mode;
    ch_t              fixed_sel;
    logic             busy;

    // Producer/consumer/software side
    modport master (
        output in_data, in_valid, out_ready, mode, fixed_sel,
        input  in_ready, out_data, out_valid, sel, busy
    );

    // Dispatcher side
    modport slave (
        input  in_data, in_valid, out_ready, mode, fixed_sel,
        output in_ready, out_data, out_valid, sel, busy
    );
endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotate-priority pick of one of four requesters starting after ptr
module rr_pick4
    import demux_pkg::*;
(
    input  ch_t        ptr,
    input  logic [3:0] req,
    output ch_t        idx,
    output logic       found
);

    ch_t cand;

    // Scan ptr+1, ptr+2, ptr+3, ptr; the first requester wins
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// rtl/demux_dispatch.sv - burst-granular dispatcher of one stream onto four consumers
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
)(
    input  logic             clk,
    input  logic             reset,
    demux_dispatch_if.slave  bus
);

    localparam int             CW   = $clog2(BURST + 1);
    localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

    state_t           state;
    state_t           state_nx;
    ch_t              ptr;
    ch_t              sel;
    logic [CW-1:0]    cnt;
    logic             hv;
    logic [WIDTH-1:0] hd;

    ch_t              pick_idx;
    logic             pick_found;
    logic             grant;
    ch_t              grant_ch;
    logic             ptr_upd;
    logic             in_ready;
    logic             in_acc;
    logic             out_acc;

    rr_pick4 u_pick (
        .ptr   (ptr),
        .req   (bus.out_ready),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign out_acc       = hv && bus.out_ready[sel];
    assign in_acc        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = hv ? (NCH'(1) << sel) : '0;
    assign bus.out_data  = hd;
    assign bus.sel       = sel;
    assign bus.busy      = (state != ARB);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, grant decision and input-ready generation
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_ch = sel;
        ptr_upd  = 1'b0;
        in_ready = 1'b0;
        case (state)
            ARB: begin
                if (bus.in_valid) begin
                    if (bus.mode) begin
                        grant    = 1'b1;
                        grant_ch = bus.fixed_sel;
                    end else if (pick_found) begin
                        grant    = 1'b1;
                        grant_ch = pick_idx;
                        ptr_upd  = 1'b1;
                    end
                end
                if (grant) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                in_ready = !hv || bus.out_ready[sel];
                if (in_ready && bus.in_valid && cnt == LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!hv || out_acc) begin
                    state_nx = ARB;
                end
            end
            default: begin
                state_nx = ARB;
            end
        endcase
    end

    // Grant bookkeeping, burst counter and one-entry hold register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'd3;
            sel <= 2'd0;
            cnt <= '0;
            hv  <= 1'b0;
            hd  <= '0;
        end else begin
            if (grant) begin
                sel <= grant_ch;
                cnt <= '0;
            end else if (in_acc) begin
                cnt <= cnt + 1'b1;
            end
            if (ptr_upd) begin
                ptr <= grant_ch;
            end
            if (in_acc) begin
                hv <= 1'b1;
                hd <= bus.in_data;
            end else if (out_acc) begin
                hv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// tb/tb_demux_dispatch.sv - self-checking bench for demux_dispatch
module tb_demux_dispatch;
    import demux_pkg::*;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_dispatch_if #(.WIDTH(WIDTH)) bus ();

    demux_dispatch #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        int         ch;
    } item_t;

    int         checks = 0;
    int         errors = 0;
    int         accepted = 0;
    bit         auto_rand = 0;
    int         obs_ch [256];
    item_t      sb [$];

    // Reference model: a grant is either open (m_busy) or not; an open grant
    // owns channel m_ch and has taken m_taken of its BURST items so far.
    bit         m_busy;
    int         m_ch;
    int         m_ptr;
    int         m_taken;
    bit         m_hv;
    logic [7:0] m_hd;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_ch    = 0;
        m_ptr   = 3;
        m_taken = 0;
        m_hv    = 0;
        m_hd    = 8'h00;
        sb.delete();
    endtask

    task automatic step();
        logic [3:0] rdy;
        logic [3:0] exp_ov;
        bit         exp_ir;
        bit         acc_in;
        bit         acc_out;
        bit         iv;
        bit         md;
        int         fs;
        logic [7:0] din;
        int         oc;
        item_t      e;
        int         c;
        bit         found;
        #1;
        rdy    = bus.out_ready;
        iv     = bus.in_valid;
        md     = bus.mode;
        fs     = int'(bus.fixed_sel);
        din    = bus.in_data;
        exp_ir = m_busy && (m_taken < BURST) && (!m_hv || rdy[m_ch]);
        exp_ov = m_hv ? 4'(1 << m_ch) : 4'b0000;
        check("in_ready",  32'(bus.in_ready),  32'(exp_ir));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("out_data",  32'(bus.out_data),  32'(m_hd));
        check("sel",       32'(bus.sel),       32'(m_ch));
        check("busy",      32'(bus.busy),      32'(m_busy));
        acc_in  = iv && exp_ir;
        acc_out = m_hv && rdy[m_ch];
        if (!reset && acc_out) begin
            oc = -1;
            for (int i = 0; i < 4; i++) if (bus.out_valid[i]) oc = i;
            if (sb.size() == 0) begin
                check("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_data", 32'(bus.out_data), 32'(e.d));
                check("sb_ch",   32'(oc),           32'(e.ch));
            end
            obs_ch[bus.out_data] = oc;
        end
        if (!reset && acc_in) begin
            sb.push_back('{din, m_ch});
            accepted++;
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (iv) begin
                if (md) begin
                    m_ch = fs; m_busy = 1; m_taken = 0;
                end else begin
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_ptr + k) % 4;
                        if (!found && rdy[c]) begin
                            found = 1; m_ch = c; m_ptr = c; m_busy = 1; m_taken = 0;
                        end
                    end
                end
            end
        end else begin
            if (acc_in) begin
                m_hv = 1; m_hd = din; m_taken++;
            end else if (acc_out) begin
                m_hv = 0;
            end
            if (m_taken == BURST && !acc_in && (!m_hv || acc_out || !m_hv)) begin
                if (!acc_out && m_hv) begin
                end else begin
                    m_busy = 0;
                end
            end
        end
        #1;
        if (!reset && acc_in) begin
            bus.in_data = auto_rand ? 8'($urandom) : din + 8'd1;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic run_accept(int n, int limit);
        int start;
        int c;
        start = accepted;
        c = 0;
        while ((accepted - start) < n && c < limit) begin
            step();
            c++;
        end
        check("accept_budget", 32'(accepted - start), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) obs_ch[i] = -1;
        reset         = 1;
        bus.in_valid  = 1;
        bus.in_data   = 8'h55;
        bus.out_ready = 4'hF;
        bus.mode      = 0;
        bus.fixed_sel = 2'd0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held a second cycle with in_valid high
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_sel",       32'(bus.sel),       32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        reset = 0;

        // Round robin, all ready, 8 items back to back
        bus.in_data = 8'h00;
        run_accept(8, 40);
        bus.in_valid = 0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) check("rr_ch", 32'(obs_ch[i]), 32'(i / 4));

        // Skip a non-ready channel at the second arbitration
        do_reset();
        bus.in_data  = 8'h10;
        bus.in_valid = 1;
        run_accept(4, 20);
        bus.in_valid = 0;
        repeat (3) step();
        bus.out_ready = 4'b1101;
        bus.in_valid  = 1;
        step();
        check("skip_sel", 32'(bus.sel), 32'd2);
        run_accept(4, 20);
        bus.in_valid = 0;
        repeat (3) step();
        bus.out_ready = 4'hF;
        bus.in_valid  = 1;
        run_accept(4, 20);
        bus.in_valid = 0;
        repeat (3) step();
        check("skip_ch0", 32'(obs_ch[8'h10]), 32'd0);
        check("skip_ch2", 32'(obs_ch[8'h14]), 32'd2);
        check("skip_ch3", 32'(obs_ch[8'h18]), 32'd3);

        // Backpressure from channel 0 mid-burst
        do_reset();
        bus.in_data  = 8'h20;
        bus.in_valid = 1;
        run_accept(2, 10);
        bus.out_ready = 4'b1110;
        repeat (3) begin
            step();
            check("bp_data",     32'(bus.out_data), 32'h21);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 4'hF;
        run_accept(2, 10);
        bus.in_valid = 0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) check("bp_ch", 32'(obs_ch[8'h20 + i]), 32'd0);

        // Fixed channel 3
        do_reset();
        bus.mode      = 1;
        bus.fixed_sel = 2'd3;
        bus.in_data   = 8'h30;
        bus.in_valid  = 1;
        begin
            int start;
            int c;
            start = accepted;
            c = 0;
            while ((accepted - start) < 8 && c < 40) begin
                step();
                check("fix_sel", 32'(bus.sel), 32'd3);
                check("fix_ov", 32'(bus.out_valid == 4'b0000 || bus.out_valid == 4'b1000), 32'd1);
                c++;
            end
            check("fix_budget", 32'(accepted - start), 32'd8);
        end
        bus.in_valid = 0;
        repeat (3) step();
        for (int i = 0; i < 8; i++) check("fix_ch", 32'(obs_ch[8'h30 + i]), 32'd3);
        bus.mode = 0;

        // Reset after 2 of 4 items
        do_reset();
        bus.in_data  = 8'h40;
        bus.in_valid = 1;
        run_accept(2, 10);
        do_reset();
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_busy",      32'(bus.busy),      32'd0);
        check("mid_in_ready",  32'(bus.in_ready),  32'd0);
        step();
        check("mid_regrant", 32'(bus.sel), 32'd0);

        // Randomized traffic against the model
        do_reset();
        auto_rand = 1;
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = 4'($urandom);
            if ($urandom_range(0, 7) == 0) bus.mode = 1'($urandom);
            bus.fixed_sel = 2'($urandom);
            step();
        end
        bus.in_valid  = 0;
        bus.out_ready = 4'hF;
        repeat (6) step();
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
